// File: rtl/ofm_drain_pkg.sv
// Shared accelerator definitions for the output-feature-map drain path:
// buffer geometry, lane count and the drain FSM state encoding.
package ofm_drain_pkg;

  localparam int OFM_ADDR_W = 8;   // output-buffer address width
  localparam int OFM_WORD_W = 64;  // output-buffer word width
  localparam int OFM_LANE_W = 16;  // one partial-sum lane
  localparam int OFM_LANES  = 4;   // lanes per buffer word

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SEND  = 3'd3,
    DONE  = 3'd4
  } ofm_state_e;

endpackage

// File: rtl/ofm_drain.sv
// Drains num_words words from the output buffer and streams each word out
// as four 16-bit partial-sum lanes, most significant lane first.
//
// Handshake: psum_valid/psum_ready follow strict valid/ready semantics. A lane
// moves only on a rising edge where both are 1. Once psum_valid is raised it
// stays high, and psum_data/psum_last stay stable, until that lane is
// accepted. psum_valid never depends combinationally on psum_ready.
module ofm_drain
  import ofm_drain_pkg::*;
#(
  parameter int ADDR_W = OFM_ADDR_W,
  parameter int WORD_W = OFM_WORD_W,
  parameter int LANE_W = OFM_LANE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  output logic              out_ena,
  output logic [ADDR_W-1:0] out_addr,
  input  logic [WORD_W-1:0] out_dout,
  output logic [LANE_W-1:0] psum_data,
  output logic              psum_valid,
  input  logic              psum_ready,
  output logic              psum_last,
  output logic              busy,
  output logic              done,
  output ofm_state_e        dbg_state
);

  localparam int LANE_IDX_W = $clog2(OFM_LANES);
  localparam logic [LANE_IDX_W-1:0] LANE_LAST = LANE_IDX_W'(OFM_LANES - 1);

  ofm_state_e            state_q, state_d;
  logic [ADDR_W:0]       num_q;    // word count latched at start
  logic [ADDR_W-1:0]     addr_q;   // word counter, doubles as read address
  logic [LANE_IDX_W-1:0] lane_q;   // lane currently presented
  logic [WORD_W-1:0]     hold_q;   // word being unpacked
  logic                  final_word;
  logic                  word_sent;

  // Counter reaches num-1 on the last word; num=256 ends at address 255.
  assign final_word = ({1'b0, addr_q} == (num_q - (ADDR_W + 1)'(1)));
  assign word_sent  = (state_q == SEND) && psum_ready && (lane_q == LANE_LAST);

  // State register plus datapath registers, all cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      num_q   <= '0;
      addr_q  <= '0;
      lane_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            num_q  <= num_words;
            addr_q <= '0;
          end
        end
        LOAD: begin
          hold_q <= out_dout;
          lane_q <= '0;
        end
        SEND: begin
          if (psum_ready) begin
            lane_q <= lane_q + LANE_IDX_W'(1);
            if (lane_q == LANE_LAST && !final_word) begin
              addr_q <= addr_q + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state logic: one read per word, then four lane handshakes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (num_words == '0) ? DONE : FETCH;
        end
      end
      FETCH: state_d = LOAD;
      LOAD:  state_d = SEND;
      SEND: begin
        if (word_sent) begin
          state_d = final_word ? DONE : FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane mux: lane 0 is the top 16 bits of the held word.
  always_comb begin
    psum_data = '0;
    for (int i = 0; i < OFM_LANES; i++) begin
      if (lane_q == LANE_IDX_W'(i)) begin
        psum_data = hold_q[WORD_W-1-i*LANE_W -: LANE_W];
      end
    end
  end

  // Status and strobes decoded straight from the registered state.
  always_comb begin
    out_ena    = (state_q == FETCH);
    out_addr   = addr_q;
    psum_valid = (state_q == SEND);
    psum_last  = (state_q == SEND) && (lane_q == LANE_LAST) && final_word;
    busy       = (state_q != IDLE);
    done       = (state_q == DONE);
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_ofm_drain.sv
// Self-checking bench for ofm_drain: a buffer model answers reads one cycle
// after out_ena, expected lanes and read addresses are queued at start and
// popped as the DUT produces them.
module tb_ofm_drain;
  import ofm_drain_pkg::*;

  localparam int ADDR_W = 8;
  localparam int WORD_W = 64;
  localparam int LANE_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W:0]   num_words;
  logic              out_ena;
  logic [ADDR_W-1:0] out_addr;
  logic [WORD_W-1:0] out_dout;
  logic [LANE_W-1:0] psum_data;
  logic              psum_valid;
  logic              psum_ready;
  logic              psum_last;
  logic              busy;
  logic              done;
  ofm_state_e        dbg_state;

  ofm_drain #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .LANE_W(LANE_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .out_ena(out_ena), .out_addr(out_addr), .out_dout(out_dout),
    .psum_data(psum_data), .psum_valid(psum_valid), .psum_ready(psum_ready),
    .psum_last(psum_last), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // Clock and output-buffer model.
  always #5 clk = ~clk;

  logic [WORD_W-1:0] mem [256];
  always @(posedge clk) if (out_ena) out_dout <= mem[out_addr];

  // Scoreboard state.
  logic [LANE_W:0]   exp_q[$];       // {last, data}
  logic [ADDR_W-1:0] exp_addr_q[$];
  int vectors = 0, miscompares = 0;
  int cyc = 0, start_cyc = 0, first_valid_cyc = 0, done_cyc = 0;
  int xfer_cnt = 0, done_cnt = 0, ena_cnt = 0, valid_cnt = 0, last_cnt = 0, stall_cnt = 0;
  bit want_first = 0;
  logic [ADDR_W-1:0] last_addr = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor, called at the falling edge.
  task automatic sample();
    if (rst) return;
    if (out_ena) begin
      ena_cnt++;
      last_addr = out_addr;
      if (exp_addr_q.size() == 0) chk("spurious_read", 64'd1, 64'd0);
      else chk("read_addr", 64'(out_addr), 64'(exp_addr_q.pop_front()));
    end
    if (psum_valid) begin
      valid_cnt++;
      if (want_first) begin first_valid_cyc = cyc; want_first = 0; end
    end
    if (psum_valid && psum_ready) begin
      xfer_cnt++;
      if (psum_last) last_cnt++;
      if (exp_q.size() == 0) chk("spurious_lane", 64'd1, 64'd0);
      else chk("lane", 64'({psum_last, psum_data}), 64'(exp_q.pop_front()));
    end
    if (psum_valid && !psum_ready) begin
      stall_cnt++;
      if (exp_q.size() != 0) chk("stall_hold", 64'({psum_last, psum_data}), 64'(exp_q[0]));
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
  endtask

  // One clock: sample at negedge, return 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Queue expectations for a drain of nw words and raise start this cycle.
  task automatic kick(input int nw);
    logic [WORD_W-1:0] wd;
    for (int w = 0; w < nw; w++) begin
      exp_addr_q.push_back(ADDR_W'(w));
      wd = mem[w];
      for (int l = 0; l < 4; l++) begin
        exp_q.push_back({(w == nw - 1) && (l == 3), LANE_W'(wd >> (LANE_W * (3 - l)))});
      end
    end
    num_words  = (ADDR_W + 1)'(nw);
    start      = 1'b1;
    start_cyc  = cyc;
    want_first = 1;
  endtask

  // Run a drain to completion. mode 0: ready high, 1: random ready,
  // 2: ready low during cycles 4..6 (lane 1 of the first word).
  task automatic run(input int nw, input int mode, input int repulse_at, input int budget);
    int n;
    int d0;
    bit got_done;
    n = 0;
    got_done = 0;
    kick(nw);
    while (!got_done && n < budget) begin
      d0 = done_cnt;
      tick();
      n++;
      if (done_cnt != d0) got_done = 1;
      start = 1'b0;
      if (n == repulse_at) begin start = 1'b1; num_words = 9'd5; end
      case (mode)
        1:       psum_ready = 1'($urandom_range(0, 1));
        2:       psum_ready = !(n >= 4 && n < 7);
        default: psum_ready = 1'b1;
      endcase
    end
    psum_ready = 1'b1;
    start = 1'b0;
    if (!got_done) chk("done_timeout", 64'd0, 64'd1);
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    chk("exp_addr_empty", 64'(exp_addr_q.size()), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0, d0, e0, v0, l0, s0, nw;

    // Reset state.
    rst = 1'b1; start = 1'b0; num_words = '0; psum_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_ena", 64'(out_ena), 64'd0);
    chk("rst_out_addr", 64'(out_addr), 64'd0);
    chk("rst_psum_data", 64'(psum_data), 64'd0);
    chk("rst_psum_valid", 64'(psum_valid), 64'd0);
    chk("rst_psum_last", 64'(psum_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    rst = 1'b0;
    tick();

    // Two known words, ready held high.
    mem[0] = 64'h0001_0002_0003_0004;
    mem[1] = 64'h0005_0006_0007_0008;
    x0 = xfer_cnt; d0 = done_cnt; l0 = last_cnt;
    run(2, 0, 0, 40);
    chk("two_word_latency", 64'(first_valid_cyc - start_cyc), 64'd3);
    chk("two_word_done_cyc", 64'(done_cyc - start_cyc), 64'd13);
    chk("two_word_xfers", 64'(xfer_cnt - x0), 64'd8);
    chk("two_word_dones", 64'(done_cnt - d0), 64'd1);
    chk("two_word_lasts", 64'(last_cnt - l0), 64'd1);
    tick();

    // One word, downstream stalls on lane 1 for three cycles.
    x0 = xfer_cnt; s0 = stall_cnt;
    run(1, 2, 0, 40);
    chk("stall_cycles", 64'(stall_cnt - s0), 64'd3);
    chk("stall_xfers", 64'(xfer_cnt - x0), 64'd4);
    tick();

    // Zero-word drain: straight to done, no read, no lane.
    e0 = ena_cnt; v0 = valid_cnt; d0 = done_cnt;
    run(0, 0, 0, 10);
    chk("zero_done_cyc", 64'(done_cyc - start_cyc), 64'd1);
    chk("zero_reads", 64'(ena_cnt - e0), 64'd0);
    chk("zero_valids", 64'(valid_cnt - v0), 64'd0);
    chk("zero_dones", 64'(done_cnt - d0), 64'd1);
    tick();

    // Reset during the second word of a three-word drain.
    mem[0] = {$urandom, $urandom};
    x0 = xfer_cnt; d0 = done_cnt;
    kick(3);
    for (int i = 0; i < 60 && (xfer_cnt - x0) < 5; i++) begin
      tick();
      start = 1'b0;
    end
    chk("mid_rst_reached", 64'(xfer_cnt - x0), 64'd5);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_out_ena", 64'(out_ena), 64'd0);
    chk("mid_rst_out_addr", 64'(out_addr), 64'd0);
    chk("mid_rst_psum_valid", 64'(psum_valid), 64'd0);
    chk("mid_rst_psum_data", 64'(psum_data), 64'd0);
    chk("mid_rst_psum_last", 64'(psum_last), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    exp_q.delete();
    exp_addr_q.delete();
    want_first = 0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
    mem[0] = 64'hdead_beef_cafe_f00d;
    run(1, 0, 0, 20);
    chk("restart_done_cyc", 64'(done_cyc - start_cyc), 64'd7);
    tick();

    // Start re-pulsed with a different count while busy.
    for (int i = 0; i < 8; i++) mem[i] = {$urandom, $urandom};
    x0 = xfer_cnt; d0 = done_cnt;
    run(2, 0, 3, 40);
    tick();
    tick();
    chk("repulse_xfers", 64'(xfer_cnt - x0), 64'd8);
    chk("repulse_dones", 64'(done_cnt - d0), 64'd1);
    chk("repulse_idle", 64'(busy), 64'd0);

    // A few random drains with random back-pressure.
    for (int k = 0; k < 3; k++) begin
      nw = $urandom_range(1, 6);
      d0 = done_cnt;
      run(nw, 1, 0, 20 * nw + 20);
      chk("rand_dones", 64'(done_cnt - d0), 64'd1);
      tick();
    end

    // Full 256-word drain.
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
    x0 = xfer_cnt; l0 = last_cnt; e0 = ena_cnt;
    run(256, 0, 0, 1700);
    chk("full_xfers", 64'(xfer_cnt - x0), 64'd1024);
    chk("full_reads", 64'(ena_cnt - e0), 64'd256);
    chk("full_last_addr", 64'(last_addr), 64'd255);
    chk("full_lasts", 64'(last_cnt - l0), 64'd1);
    chk("full_done_cyc", 64'(done_cyc - start_cyc), 64'd1537);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
